// File: rtl/tmds_encoder_pipe.sv
// tmds_encoder_pipe
// Multi-channel DVI TMDS encoder with a two-stage pipeline. It sits between the
// pixel/timing source and the 10:1 serialisers. Stage 1 applies the 8b->9b
// transition-minimising code. Stage 2 applies DC balancing against a per-channel
// running disparity, or emits a control-period symbol.
//
// Ports
//   i_clk    pixel-domain clock
//   i_rst    synchronous active-high reset; overrides i_ce
//   i_ce     pixel enable; both pipeline stages advance only when high
//   i_de     1 = video period, 0 = control period (shared by all channels)
//   i_data   pixel bytes, channel n at [8n+7:8n]
//   i_ctrl   control bits {C1,C0}, channel n at [2n+1:2n]
//   tmds_o   10-bit symbols, channel n at [10n+9:10n], bit 0 sent first
//   valid_o  high on the cycle after an i_ce edge that loaded a pipelined symbol
module tmds_encoder_pipe #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ce,
  input  logic                  i_de,
  input  logic [8*NUM_CH-1:0]   i_data,
  input  logic [2*NUM_CH-1:0]   i_ctrl,
  output logic [10*NUM_CH-1:0]  tmds_o,
  output logic                  valid_o
);

  localparam logic [9:0]       CTRL_00 = 10'b1101010100;
  localparam logic [9:0]       CTRL_01 = 10'b0010101011;
  localparam logic [9:0]       CTRL_10 = 10'b0101010100;
  localparam logic [9:0]       CTRL_11 = 10'b1010101011;
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  // The XOR or XNOR chain is chosen to minimise transitions. XNOR is the same
  // as XOR followed by an inversion, so use_xnor is simply folded into every link.
  function automatic logic [8:0] min_transition(input logic [7:0] d);
    logic [3:0] ones;
    logic       use_xnor;
    logic [8:0] q;
    ones = '0;
    for (int i = 0; i < 8; i++) ones = ones + {3'b000, d[i]};
    use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i] ^ use_xnor;
    q[8] = ~use_xnor;
    return q;
  endfunction

  logic                s1_de;
  logic [2*NUM_CH-1:0] s1_ctrl;
  logic                s1_valid;

  // These are the stage-1 controls that all channels share.
  // s1_valid marks that stage 1 holds real input data.
  // valid_o pulses only on cycles where stage 2 reloaded from a filled stage 1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_de    <= 1'b0;
      s1_ctrl  <= '0;
      s1_valid <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= i_ce & s1_valid;
      if (i_ce) begin
        s1_de    <= i_de;
        s1_ctrl  <= i_ctrl;
        s1_valid <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [8:0]       s1_qm;
    logic [9:0]       sym;
    logic [9:0]       sym_next;
    // cnt holds the running disparity as a two's-complement value.
    // The sign tests below read its MSB directly.
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] n1_ext;
    logic [CNT_W-1:0] n0_ext;
    logic [CNT_W-1:0] diff;
    logic [3:0]       n1;
    logic             cnt_zero;
    logic             cnt_pos;
    logic             cnt_neg;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        s1_qm <= '0;
      end else if (i_ce) begin
        s1_qm <= min_transition(i_data[8*g +: 8]);
      end
    end

    // Stage-2 DC balancing. diff = N1 - N0 of q_m[7:0]. The three video cases
    // choose between sending the word as-is and sending it inverted. Bit 9 flags
    // inversion so the disparity drifts back toward zero.
    always_comb begin
      sym_next = CTRL_00;
      cnt_next = '0;
      n1       = '0;
      for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, s1_qm[i]};
      n1_ext   = {{(CNT_W-4){1'b0}}, n1};
      n0_ext   = {{(CNT_W-4){1'b0}}, 4'd8 - n1};
      diff     = n1_ext - n0_ext;
      cnt_zero = (cnt == '0);
      cnt_neg  = cnt[CNT_W-1];
      cnt_pos  = !cnt_neg && !cnt_zero;
      if (!s1_de) begin
        case (s1_ctrl[2*g +: 2])
          2'b00:   sym_next = CTRL_00;
          2'b01:   sym_next = CTRL_01;
          2'b10:   sym_next = CTRL_10;
          default: sym_next = CTRL_11;
        endcase
      end else if (cnt_zero || (n1 == 4'd4)) begin
        sym_next = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
        cnt_next = s1_qm[8] ? cnt + diff : cnt - diff;
      end else if ((cnt_pos && (n1 > 4'd4)) || (cnt_neg && (n1 < 4'd4))) begin
        sym_next = {1'b1, s1_qm[8], ~s1_qm[7:0]};
        cnt_next = cnt - diff + (s1_qm[8] ? TWO : '0);
      end else begin
        sym_next = {1'b0, s1_qm[8], s1_qm[7:0]};
        cnt_next = cnt + diff - (s1_qm[8] ? '0 : TWO);
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        sym <= CTRL_00;
        cnt <= '0;
      end else if (i_ce) begin
        sym <= sym_next;
        cnt <= cnt_next;
      end
    end

    assign tmds_o[10*g +: 10] = sym;
  end

endmodule
